// File: rtl/instr_fetch_if.sv
// Port bundle between the instruction fetch stage and its host/CPU side.
// The master modport drives program load, control and CPU feedback; the slave is the fetch stage.
interface instr_fetch_if #(
  parameter int AW = 8,
  parameter int IW = 21
);
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [IW-1:0] LD_DATA;
  logic          START;
  logic          STALL;
  logic [7:0]    FLAGS;
  logic [AW-1:0] JREG;
  logic [IW-1:0] INS;
  logic [AW-1:0] PC;
  logic          RUNNING;
  logic          HALTED;

  modport master (
    output LD_EN, LD_ADDR, LD_DATA, START, STALL, FLAGS, JREG,
    input  INS, PC, RUNNING, HALTED
  );

  modport slave (
    input  LD_EN, LD_ADDR, LD_DATA, START, STALL, FLAGS, JREG,
    output INS, PC, RUNNING, HALTED
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-cycle instruction fetch: loadable program memory, PC, and jump resolution
// against CPU flags so a taken jump delivers its target on the very next edge.
module instr_fetch #(
  parameter int             AW  = 8,
  parameter int             IW  = 21,
  parameter logic [IW-1:0]  NOP = 21'h078000
) (
  input  logic         CLK,
  input  logic         RST,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_p0, pc_nxt;
  logic [IW-1:0] ins_p0, ins_nxt;
  logic          running_p0, halted_p0;

  logic [IW-1:0] mem [2**AW];

  logic          is_jump, is_halt, taken;
  logic [3:0]    op;
  logic [AW-1:0] tgt, jump_addr;
  logic [4:0]    flags_unused;

  function automatic logic cond_taken(input logic [3:0] code, input logic [2:0] znc);
    case (code)
      4'h0:    return 1'b1;
      4'h1:    return znc[0];
      4'h2:    return !znc[0];
      4'h3:    return znc[1];
      4'h4:    return !znc[1];
      4'h5:    return znc[2];
      4'h6:    return !znc[2];
      default: return 1'b0;
    endcase
  endfunction

  assign flags_unused = bus.FLAGS[7:3];

  assign is_jump   = (ins_p0[IW-1:IW-2] == 2'b00);
  assign op        = ins_p0[17:14];
  assign is_halt   = is_jump && (op == 4'hF);
  assign tgt       = ins_p0[18] ? ins_p0[AW-1:0] : bus.JREG;
  assign taken     = is_jump && cond_taken(op, bus.FLAGS[2:0]);
  assign jump_addr = taken ? tgt : pc_p0 + AW'(1);

  // Program memory: writes are blocked while running; reads are combinational,
  // so a same-edge load and fetch returns the pre-write word.
  always_ff @(posedge CLK) begin
    if (bus.LD_EN && state != S_RUN) begin
      mem[bus.LD_ADDR] <= bus.LD_DATA;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    ins_nxt   = ins_p0;
    case (state)
      S_RUN: begin
        if (!bus.STALL) begin
          if (is_halt) begin
            state_nxt = S_HALT;
            ins_nxt   = NOP;
          end else begin
            pc_nxt  = jump_addr;
            ins_nxt = mem[jump_addr];
          end
        end
      end
      default: begin
        ins_nxt = NOP;
        if (bus.START) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          ins_nxt   = mem[{AW{1'b0}}];
        end
      end
    endcase
  end

  // Fetch register stage p0: instruction word, its address, and decoded status
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      pc_p0      <= '0;
      ins_p0     <= NOP;
      running_p0 <= 1'b0;
      halted_p0  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_p0      <= pc_nxt;
      ins_p0     <= ins_nxt;
      running_p0 <= (state_nxt == S_RUN);
      halted_p0  <= (state_nxt == S_HALT);
    end
  end

  assign bus.INS     = ins_p0;
  assign bus.PC      = pc_p0;
  assign bus.RUNNING = running_p0;
  assign bus.HALTED  = halted_p0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program scenarios plus randomized traffic,
// compared each cycle against a behavioural program-execution model.
module tb_instr_fetch;
  localparam int            AW   = 8;
  localparam int            IW   = 21;
  localparam logic [IW-1:0] NOP  = 21'h078000;
  localparam logic [IW-1:0] HALT = 21'h07C000;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  instr_fetch_if #(.AW(AW), .IW(IW)) bus ();
  instr_fetch #(.AW(AW), .IW(IW), .NOP(NOP)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model state: program image, whether executing, whether halted, current PC and word
  logic [IW-1:0] mm [256];
  bit            m_run, m_halt;
  logic [7:0]    m_pc;
  logic [IW-1:0] m_ins;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
  endtask

  function automatic logic [20:0] mov(input logic [7:0] a);
    return 21'h100000 | {13'd0, a} | {5'd0, a, 8'd0};
  endfunction

  function automatic logic [20:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    return r[20:0];
  endfunction

  function automatic bit spec_taken(input logic [3:0] op, input logic [7:0] f);
    int idx;
    if (op == 4'd0) return 1'b1;
    if (op > 4'd6) return 1'b0;
    idx = (int'(op) - 1) / 2;
    return op[0] ? f[idx] : !f[idx];
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_pc = 8'h00; m_ins = NOP;
  endtask

  task automatic model_step();
    logic [IW-1:0] w;
    logic [3:0]    op;
    logic [7:0]    nxt;
    bit            was_run, jmp;
    was_run = m_run;
    if (!m_run) begin
      if (bus.START) begin
        m_run = 1; m_halt = 0; m_pc = 8'h00; m_ins = mm[0];
      end else begin
        m_ins = NOP;
      end
    end else if (!bus.STALL) begin
      w   = m_ins;
      op  = w[17:14];
      jmp = (w[20:19] == 2'b00);
      if (jmp && op == 4'hF) begin
        m_run = 0; m_halt = 1; m_ins = NOP;
      end else begin
        if (jmp && spec_taken(op, bus.FLAGS)) nxt = w[18] ? w[7:0] : bus.JREG;
        else nxt = m_pc + 8'd1;
        m_pc  = nxt;
        m_ins = mm[nxt];
      end
    end
    if (bus.LD_EN && !was_run) mm[bus.LD_ADDR] = bus.LD_DATA;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_step();
    #1;
  endtask

  task automatic do_rst();
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_INS", 32'(bus.INS), 32'(NOP));
    chk("rst_PC", 32'(bus.PC), 32'h0);
    chk("rst_RUNNING", 32'(bus.RUNNING), 32'h0);
    chk("rst_HALTED", 32'(bus.HALTED), 32'h0);
    RST = 1'b0;
  endtask

  task automatic ld(input logic [7:0] a, input logic [20:0] d);
    bus.LD_EN = 1'b1; bus.LD_ADDR = a; bus.LD_DATA = d;
    tick();
    bus.LD_EN = 1'b0;
  endtask

  task automatic start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic expect_pi(input string name, input logic [7:0] pc, input logic [20:0] ins);
    chk({name, "_PC"}, 32'(bus.PC), 32'(pc));
    chk({name, "_INS"}, 32'(bus.INS), 32'(ins));
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_INS", 32'(bus.INS), 32'(m_ins));
      chk("cyc_PC", 32'(bus.PC), 32'(m_pc));
      chk("cyc_RUNNING", 32'(bus.RUNNING), 32'(m_run));
      chk("cyc_HALTED", 32'(bus.HALTED), 32'(m_halt));
      chk("cyc_exclusive", 32'(bus.RUNNING & bus.HALTED), 32'h0);
    end
  end

  initial begin
    bus.LD_EN = 0; bus.LD_ADDR = '0; bus.LD_DATA = '0;
    bus.START = 0; bus.STALL = 0; bus.FLAGS = '0; bus.JREG = '0;
    model_reset();
    #1;
    do_rst();
    chk_en = 1'b1;

    for (int i = 0; i < 256; i++) ld(8'(i), rand_word());

    // Sequential run into a halt, with an ignored load while running
    for (int k = 0; k < 4; k++) ld(8'(k), mov(8'(k)));
    ld(8'h04, HALT);
    start();
    expect_pi("seq0", 8'h00, mov(8'h00));
    chk("seq0_RUNNING", 32'(bus.RUNNING), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        bus.LD_EN = 1'b1; bus.LD_ADDR = 8'h01; bus.LD_DATA = 21'h1ABCDE;
      end
      tick();
      bus.LD_EN = 1'b0;
      expect_pi("seq", 8'(k), (k == 4) ? HALT : mov(8'(k)));
    end
    tick();
    expect_pi("halt", 8'h04, NOP);
    chk("halt_HALTED", 32'(bus.HALTED), 32'h1);
    chk("halt_RUNNING", 32'(bus.RUNNING), 32'h0);

    // Restart with a same-edge load of address 0: old word fetched first
    bus.LD_EN = 1'b1; bus.LD_ADDR = 8'h00; bus.LD_DATA = 21'h155555;
    start();
    bus.LD_EN = 1'b0;
    expect_pi("rbw", 8'h00, mov(8'h00));
    tick();
    expect_pi("run_ld_ignored", 8'h01, mov(8'h01));
    repeat (4) tick();
    chk("halt2_HALTED", 32'(bus.HALTED), 32'h1);
    start();
    expect_pi("new_word", 8'h00, 21'h155555);
    do_rst();

    // Conditional immediate jump and register jump
    ld(8'h00, mov(8'h00)); ld(8'h01, mov(8'h01)); ld(8'h02, 21'h044010);
    ld(8'h03, mov(8'h03)); ld(8'h04, HALT); ld(8'h10, 21'h000000); ld(8'h40, HALT);
    bus.FLAGS = 8'h01; bus.JREG = 8'h40;
    start(); tick(); tick();
    expect_pi("jz_at", 8'h02, 21'h044010);
    tick();
    expect_pi("jz_taken", 8'h10, 21'h000000);
    tick();
    expect_pi("jreg", 8'h40, HALT);
    tick();
    chk("jreg_halt", 32'(bus.HALTED), 32'h1);
    bus.FLAGS = 8'h00;
    start(); tick(); tick(); tick();
    expect_pi("jz_not_taken", 8'h03, mov(8'h03));
    do_rst();

    // Stall, wrap past 0xFF, and reset in the middle of a run
    ld(8'h00, 21'h040005);
    for (int k = 5; k < 10; k++) ld(8'(k), mov(8'(k)));
    ld(8'h0A, 21'h0400FE); ld(8'hFE, mov(8'hFE)); ld(8'hFF, mov(8'hFF));
    start(); tick(); tick(); tick();
    expect_pi("pre_stall", 8'h07, mov(8'h07));
    bus.STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_pi("stall", 8'h07, mov(8'h07));
    end
    bus.STALL = 1'b0;
    tick();
    expect_pi("resume", 8'h08, mov(8'h08));
    repeat (4) tick();
    expect_pi("at_ff", 8'hFF, mov(8'hFF));
    tick();
    expect_pi("wrap", 8'h00, 21'h040005);
    tick();
    expect_pi("pre_rst", 8'h05, mov(8'h05));
    do_rst();
    start();
    expect_pi("mem_kept", 8'h00, 21'h040005);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.STALL   = ($urandom_range(0, 4) == 0);
      bus.FLAGS   = 8'($urandom);
      bus.JREG    = 8'($urandom);
      bus.LD_EN   = ($urandom_range(0, 7) == 0);
      bus.LD_ADDR = 8'($urandom);
      bus.LD_DATA = rand_word();
      bus.START   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) do_rst();
      else tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
